// File: rtl/imem_boot_loader_if.sv
// Byte-stream ingress and instruction-memory write bus of the boot loader.
// The master side is the loader; the slave side is the byte source plus memory.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Framed byte-stream boot loader: assembles little-endian words into instruction
// memory, verifies an XOR checksum and only then releases the CPU from reset.
module imem_boot_loader #(
  parameter int         ADDR_W = 10,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  imem_boot_loader_if.master bus,
  output logic               cpu_rst_n,
  input  logic               cpu_stopped,
  output logic               busy,
  output logic               load_done,
  output logic               load_error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_RUN    = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [31:0] CAP_WORDS = 32'd1 << ADDR_W;

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t            state_r, state_nx;
  logic              rx_ready_r, rx_ready_nx;
  logic              imem_we_r, imem_we_nx;
  logic [ADDR_W-1:0] imem_addr_r, imem_addr_nx;
  logic [31:0]       imem_wdata_r, imem_wdata_nx;
  logic              cpu_rst_n_r, cpu_rst_n_nx;
  logic              busy_r, busy_nx;
  logic              load_done_r, load_done_nx;
  logic              load_error_r, load_error_nx;
  logic [7:0]        len_lo_r, len_lo_nx;
  logic [15:0]       remain_r, remain_nx;
  logic [7:0]        acc_r, acc_nx;
  logic [1:0]        idx_r, idx_nx;
  logic [23:0]       sh_r, sh_nx;
  logic [ADDR_W-1:0] addr_r, addr_nx;
  logic              accept_s;
  logic [15:0]       count_s;

  assign accept_s = bus.rx_valid && rx_ready_r;
  assign count_s  = {bus.rx_data, len_lo_r};

  // Next-state and next-register computation for the frame FSM and datapath.
  always_comb begin
    state_nx      = state_r;
    imem_we_nx    = 1'b0;
    imem_addr_nx  = imem_addr_r;
    imem_wdata_nx = imem_wdata_r;
    load_done_nx  = load_done_r;
    load_error_nx = load_error_r;
    len_lo_nx     = len_lo_r;
    remain_nx     = remain_r;
    acc_nx        = acc_r;
    idx_nx        = idx_r;
    sh_nx         = sh_r;
    addr_nx       = addr_r;
    case (state_r)
      S_IDLE, S_ERROR: begin
        if (accept_s && (bus.rx_data == SYNC)) begin
          state_nx      = S_LEN_LO;
          load_done_nx  = 1'b0;
          load_error_nx = 1'b0;
          acc_nx        = 8'h00;
          addr_nx       = '0;
          idx_nx        = 2'd0;
        end else begin
          state_nx = state_r;
        end
      end
      S_LEN_LO: begin
        if (accept_s) begin
          len_lo_nx = bus.rx_data;
          state_nx  = S_LEN_HI;
        end else begin
          state_nx = S_LEN_LO;
        end
      end
      S_LEN_HI: begin
        if (accept_s) begin
          remain_nx = count_s;
          if ({16'd0, count_s} > CAP_WORDS) begin
            state_nx      = S_ERROR;
            load_error_nx = 1'b1;
          end else if (count_s == 16'd0) begin
            state_nx = S_CHECK;
          end else begin
            state_nx = S_DATA;
          end
        end else begin
          state_nx = S_LEN_HI;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          acc_nx = chk_update(acc_r, bus.rx_data);
          if (idx_r == 2'd3) begin
            // First byte lands in [7:0], so the fourth byte completes the top lane.
            imem_we_nx    = 1'b1;
            imem_addr_nx  = addr_r;
            imem_wdata_nx = {bus.rx_data, sh_r};
            addr_nx       = addr_r + ADDR_W'(1);
            remain_nx     = remain_r - 16'd1;
            idx_nx        = 2'd0;
            if (remain_r == 16'd1) begin
              state_nx = S_CHECK;
            end else begin
              state_nx = S_DATA;
            end
          end else begin
            sh_nx  = {bus.rx_data, sh_r[23:8]};
            idx_nx = idx_r + 2'd1;
          end
        end else begin
          state_nx = S_DATA;
        end
      end
      S_CHECK: begin
        if (accept_s) begin
          if (bus.rx_data == acc_r) begin
            state_nx     = S_RUN;
            load_done_nx = 1'b1;
          end else begin
            state_nx      = S_ERROR;
            load_error_nx = 1'b1;
          end
        end else begin
          state_nx = S_CHECK;
        end
      end
      S_RUN: begin
        if (cpu_stopped) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_RUN;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with it.
    rx_ready_nx  = (state_nx != S_RUN);
    cpu_rst_n_nx = (state_nx == S_RUN);
    busy_nx      = (state_nx == S_LEN_LO) || (state_nx == S_LEN_HI) ||
                   (state_nx == S_DATA)   || (state_nx == S_CHECK);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Datapath and registered output updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready_r   <= 1'b0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= '0;
      imem_wdata_r <= 32'h0000_0000;
      cpu_rst_n_r  <= 1'b0;
      busy_r       <= 1'b0;
      load_done_r  <= 1'b0;
      load_error_r <= 1'b0;
      len_lo_r     <= 8'h00;
      remain_r     <= 16'h0000;
      acc_r        <= 8'h00;
      idx_r        <= 2'd0;
      sh_r         <= 24'h00_0000;
      addr_r       <= '0;
    end else begin
      rx_ready_r   <= rx_ready_nx;
      imem_we_r    <= imem_we_nx;
      imem_addr_r  <= imem_addr_nx;
      imem_wdata_r <= imem_wdata_nx;
      cpu_rst_n_r  <= cpu_rst_n_nx;
      busy_r       <= busy_nx;
      load_done_r  <= load_done_nx;
      load_error_r <= load_error_nx;
      len_lo_r     <= len_lo_nx;
      remain_r     <= remain_nx;
      acc_r        <= acc_nx;
      idx_r        <= idx_nx;
      sh_r         <= sh_nx;
      addr_r       <= addr_nx;
    end
  end

  assign bus.rx_ready   = rx_ready_r;
  assign bus.imem_we    = imem_we_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.imem_wdata = imem_wdata_r;
  assign cpu_rst_n      = cpu_rst_n_r;
  assign busy           = busy_r;
  assign load_done      = load_done_r;
  assign load_error     = load_error_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected memory writes are queued as
// payload is driven and popped when the loader strobes imem_we.
module tb_imem_boot_loader;

  localparam int         ADDR_W = 10;
  localparam logic [7:0] SYNC   = 8'hA5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  logic cpu_rst_n;
  logic cpu_stopped;
  logic busy;
  logic load_done;
  logic load_error;

  int n_checks = 0;
  int n_fail   = 0;

  wr_t         sb_q[$];
  logic [31:0] frame_words[$];

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.ADDR_W(ADDR_W), .SYNC(SYNC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cpu_rst_n   (cpu_rst_n),
    .cpu_stopped (cpu_stopped),
    .busy        (busy),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (bus.imem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexp_we", 64'(bus.imem_we), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", 64'(bus.imem_addr), 64'(e.addr));
        check("wr_data", 64'(bus.imem_wdata), 64'(e.data));
      end
    end
  end

  // Drive one byte and return just after the edge that transfers it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    while (bus.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rdy_timeout", 64'(bus.rx_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  // Send a full frame of frame_words; chk_flip corrupts the checksum when nonzero.
  task automatic send_frame(input logic [7:0] chk_flip);
    logic [15:0] len;
    logic [7:0]  acc;
    logic [31:0] w;
    logic [7:0]  b;
    wr_t         e;
    len = 16'(frame_words.size());
    acc = 8'h00;
    send_byte(SYNC);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    for (int k = 0; k < frame_words.size(); k++) begin
      w = frame_words[k];
      e.addr = ADDR_W'(k);
      e.data = w;
      sb_q.push_back(e);
      for (int j = 0; j < 4; j++) begin
        b = w[8*j +: 8];
        acc = acc ^ b;
        send_byte(b);
      end
    end
    send_byte(acc ^ chk_flip);
  endtask

  task automatic stop_cpu();
    @(negedge clk);
    cpu_stopped = 1'b1;
    @(posedge clk);
    #1;
    cpu_stopped = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    cpu_stopped  = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // Reset values while held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("rst_we", 64'(bus.imem_we), 64'd0);
    check("rst_addr", 64'(bus.imem_addr), 64'd0);
    check("rst_wdata", 64'(bus.imem_wdata), 64'd0);
    check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(load_done), 64'd0);
    check("rst_err", 64'(load_error), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rx_ready", 64'(bus.rx_ready), 64'd1);
    check("post_rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);

    // Garbage before SYNC, then the reference two-word image.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    check("garbage_busy", 64'(busy), 64'd0);
    frame_words = '{32'h1234_5678, 32'hDEAD_BEEF};
    send_frame(8'h00);
    check("good_done", 64'(load_done), 64'd1);
    check("good_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
    check("good_err", 64'(load_error), 64'd0);
    check("run_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("run_busy", 64'(busy), 64'd0);
    check("good_sb_empty", 64'(sb_q.size()), 64'd0);

    // Stop: back to IDLE with CPU held, done stays sticky.
    stop_cpu();
    check("stop_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("stop_rx_ready", 64'(bus.rx_ready), 64'd1);
    check("stop_done_sticky", 64'(load_done), 64'd1);

    // Same image with a corrupted checksum: words are written, CPU stays held.
    send_frame(8'h01);
    check("bad_err", 64'(load_error), 64'd1);
    check("bad_done", 64'(load_done), 64'd0);
    check("bad_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("bad_rx_ready", 64'(bus.rx_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bad_cpu_hold", 64'(cpu_rst_n), 64'd0);

    // Recovery from ERROR with a different image.
    frame_words = '{32'hCAFE_F00D};
    send_frame(8'h00);
    check("recov_err_clr", 64'(load_error), 64'd0);
    check("recov_done", 64'(load_done), 64'd1);
    check("recov_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
    stop_cpu();

    // Empty image goes straight to RUN without writing.
    frame_words.delete();
    send_frame(8'h00);
    check("len0_done", 64'(load_done), 64'd1);
    check("len0_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
    stop_cpu();

    // One word past capacity is rejected right after the high length byte.
    send_byte(SYNC);
    send_byte(8'h01);
    check("ovf_busy_mid", 64'(busy), 64'd1);
    send_byte(8'h04);
    check("ovf_err", 64'(load_error), 64'd1);
    check("ovf_busy", 64'(busy), 64'd0);
    check("ovf_cpu_rst_n", 64'(cpu_rst_n), 64'd0);

    // Exactly full capacity is accepted and fills the last address.
    frame_words.delete();
    for (int k = 0; k < (1 << ADDR_W); k++) begin
      frame_words.push_back({16'(k), ~16'(k)} ^ 32'h5A3C_0F96);
    end
    send_frame(8'h00);
    check("full_done", 64'(load_done), 64'd1);
    check("full_err", 64'(load_error), 64'd0);
    check("full_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
    stop_cpu();

    // Reset after two payload bytes: partial word dropped, fresh frame starts at 0.
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    #1;
    check("midrst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("midrst_we", 64'(bus.imem_we), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame_words = '{32'h0BAD_F00D, 32'h1357_9BDF};
    send_frame(8'h00);
    check("fresh_done", 64'(load_done), 64'd1);
    check("fresh_cpu_rst_n", 64'(cpu_rst_n), 64'd1);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
